// File: rtl/seg_scan.sv
// Digit-select refresh sequencer for a 4-digit common-anode 7-segment display.
// Optional inter-digit blanking is compiled in with `define SEG_SCAN_BLANK_EN.
module seg_scan #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [3:0] sel,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 2 || DIV > (1 << 20)) begin : g_bad_div
    $error("seg_scan: DIV out of range");
  end
  if (BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_blank
    $error("seg_scan: BLANK_CYC out of range");
  end

`ifdef SEG_SCAN_BLANK_EN
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(BLANK_CYC - 1);
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
  logic [BW-1:0] bcnt_q;
`else
  typedef enum logic {IDLE, SCAN} state_t;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    sel_q;
  logic          fd_q;

  function automatic logic [3:0] dsel(input logic [1:0] i);
    dsel = ~(4'b0001 << i);
  endfunction

  // en is only ever sampled here, so every output stays a pure register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= 4'hF;
      fd_q    <= 1'b0;
`ifdef SEG_SCAN_BLANK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      fd_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        sel_q   <= 4'hF;
`ifdef SEG_SCAN_BLANK_EN
        bcnt_q  <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= SCAN;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= dsel(2'd0);
          end
          SCAN: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              idx_q <= idx_q + 2'd1;
              fd_q  <= (idx_q == 2'd3);
`ifdef SEG_SCAN_BLANK_EN
              // digit_idx moves ahead now; the next digit lights after the gap
              state_q <= BLANK;
              sel_q   <= 4'hF;
              bcnt_q  <= '0;
`else
              sel_q   <= dsel(idx_q + 2'd1);
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef SEG_SCAN_BLANK_EN
          BLANK: begin
            if (bcnt_q == BLK_LAST) begin
              state_q <= SCAN;
              sel_q   <= dsel(idx_q);
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sel        = sel_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: frame-position reference model, directed scenarios, then random en.
module tb_seg_scan;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int BL = BLANK_CYC;
`else
  localparam int BL = 0;
`endif
  localparam int DLEN = DIV + BL;
  localparam int PER  = 4 * DLEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] sel;
  logic [1:0] digit_idx;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;   // model: scanning since the last enable
  int p = 0;        // model: cycles since the first lit cycle

  seg_scan #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sel(sel), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs from the position inside the frame.
  task automatic expect_out(output logic [3:0] s, output logic [1:0] i, output logic f);
    int pos, dg, off;
    s = 4'hF; i = 2'd0; f = 1'b0;
    if (run) begin
      pos = p % PER;
      dg  = pos / DLEN;
      off = pos % DLEN;
      if (off < DIV) begin
        s = ~(4'b0001 << dg);
        i = dg[1:0];
      end else begin
        i = 2'((dg + 1) % 4);
      end
`ifdef SEG_SCAN_BLANK_EN
      f = (pos == 3 * DLEN + DIV);
`else
      f = (p > 0 && pos == 0);
`endif
    end
  endtask

  task automatic cycle(input logic e);
    logic [3:0] es;
    logic [1:0] ei;
    logic       ef;
    @(negedge clk);
    en = e;
    @(posedge clk);
    if (!e) run = 1'b0;
    else if (!run) begin run = 1'b1; p = 0; end
    else p++;
    #1;
    expect_out(es, ei, ef);
    chk("sel", sel, es);
    chk("digit_idx", digit_idx, ei);
    chk("frame_done", frame_done, ef);
    chk("onehot", 32'($countones(~sel) <= 1), 1);
  endtask

  initial begin
    logic [3:0] es;
    logic [1:0] ei;
    logic       ef;
    logic       er;
    int         k;

    // reset held with en high
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", sel, 4'hF);
    chk("rst_idx", digit_idx, 0);
    chk("rst_fd", frame_done, 0);
    rst_n = 1'b1;

    // three full frames plus wrap
    repeat (3 * PER + 2) cycle(1'b1);
    repeat (2) cycle(1'b0);

    // disable on the second cycle of digit 2, then re-enable
    repeat (2 * DLEN + 2) cycle(1'b1);
    cycle(1'b0);
    repeat (DLEN + 3) cycle(1'b1);

    // async reset while digit 2 is lit
    k = 0;
    do begin
      cycle(1'b1);
      expect_out(es, ei, ef);
      k++;
    end while (es !== 4'b1011 && k < 100);
    chk("pre_rst_sel", sel, 4'b1011);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    run   = 1'b0;
    #1;
    chk("async_sel", sel, 4'hF);
    chk("async_idx", digit_idx, 0);
    chk("async_fd", frame_done, 0);
    #2;
    rst_n = 1'b1;

    // random enable toggling
    er = 1'b1;
    repeat (10000) begin
      if ($urandom_range(0, 39) == 0) er = ~er;
      cycle(er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
